nes_joypad_mux: RTL and testbench
=================================

NES_JOYPAD_MUX -- requirements
Module: nes_joypad_mux

Interface
- REQ-001: Parameter NUM_PADS, default 2, number of attached controllers (legal 1..4).
- REQ-002: Parameter FILL_BIT, default 1, value shifted in behind the report.
- REQ-003: Parameter TURBO_DIV, default 4, strobe count per turbo half-period (legal 1..255).
- REQ-004: clk  in  1  core PPU-domain clock, all logic on posedge.
- REQ-005: reset  in  1  asynchronous, active-high reset.
- REQ-006: joypad_out  in  1  strobe/latch line from the NES core (bit 0 of core joypad_out).
- REQ-007: joypad_clock  in  2  per-port read clocks; bit 0 is port 1, bit 1 is port 2.
- REQ-008: pad_buttons  in  NUM_PADS*8  per pad {right,left,down,up,start,select,b,a}; pad n in bits [8n+7:8n].
- REQ-009: fourscore_en  in  1  selects Four Score multitap report format.
- REQ-010: turbo_a, turbo_b  in  NUM_PADS each  per-pad turbo requests (used only when JOYPAD_TURBO_EN is defined).
- REQ-011: port_data  out  2  serial data bit presented to each port; bit 0 is port 1.
- REQ-012: fourscore_active  out  1  mode latched at the most recent strobe load.

Function
- REQ-013: Each port SHALL own one 24-bit shift register; port_data[i] SHALL equal bit 0 of port i's register.
- REQ-014: While joypad_out is 1, each register SHALL reload every cycle from the current button state; shifting SHALL be suppressed.
- REQ-015: Falling edge on joypad_clock[i] SHALL be detected against a registered copy of joypad_clock[i]; it SHALL shift register i right one bit, inserting FILL_BIT at bit 23.
- REQ-016: When a reload and a falling edge occur in the same cycle, the reload SHALL win.
- REQ-017: Standard load (fourscore_en=0): port i bits [7:0] = pad i, bits [23:8] = FILL_BIT; absent pads (i >= NUM_PADS) SHALL load all 0.
- REQ-018: Four Score load (fourscore_en=1): port 1 = {8'h10, pad2, pad0}; port 2 = {8'h20, pad3, pad1}; absent pads load 8'h00.
- REQ-019: fourscore_en SHALL be sampled only on reload; fourscore_active SHALL update on that same cycle; mode change mid-read SHALL NOT alter bits already loaded.
- REQ-020: After 24 shifts without a reload, port_data[i] SHALL hold FILL_BIT indefinitely (no wrap-around).
- REQ-021: Latency: a reload or shift SHALL be visible on port_data one cycle after the qualifying clk edge.
- REQ-022: Edges on one port's clock SHALL NOT affect the other port's register.

Reset
- REQ-023: During reset, shift registers, clock-edge history, fourscore_active and turbo state SHALL clear to 0; port_data SHALL read 2'b00.
- REQ-024: Reset asserted mid-read SHALL abort the read; the next report SHALL begin only at the next strobe.
- REQ-025: Clock-edge history SHALL be 0 after reset, so a joypad_clock already low at release generates no shift.

Configuration
- REQ-026: Macro JOYPAD_TURBO_EN SHALL compile in turbo logic; without it, turbo_a/turbo_b SHALL be ignored and buttons pass unmodified.
- REQ-027: With JOYPAD_TURBO_EN, an 8-bit counter SHALL increment on each rising edge of joypad_out; on reaching TURBO_DIV-1 it SHALL return to 0 and toggle a phase bit.
- REQ-028: With JOYPAD_TURBO_EN, a pad's loaded A bit SHALL be a OR (turbo_a AND phase); its B bit SHALL be b OR (turbo_b AND phase); all other bits are unaffected.

Verification
- REQ-029: Standard mode, pad0=8'hA5, strobe 1->0, 10 falling edges on port 1 -> port_data[0] sequence 1,0,1,0,0,1,0,1,1,1.
- REQ-030: Four Score, pads 8'h01,8'h02,8'h04,8'h08, 24 edges on each port -> port 1 reads 24'h100401 LSB-first; port 2 reads 24'h200802 LSB-first; the 25th bit on each port is 1.
- REQ-031: Strobe held high while 3 falling edges are applied on port 1 -> port_data[0] stays at pad0[0] and no shift occurs.
- REQ-032: Reload and falling edge in the same cycle with pad0=8'h02 -> next-cycle port_data[0]=0 (pad0[0], reload wins).
- REQ-033: Reset asserted after 5 shifts -> port_data=2'b00; after release and a new strobe, the report restarts at bit 0.
- REQ-034: JOYPAD_TURBO_EN, TURBO_DIV=2, turbo_a[0]=1, a released, 8 strobes -> pad0 A bit pattern per strobe 0,1,1,0,0,1,1,0.

Source files
------------

// File: rtl/nes_joypad_mux.sv
// Two-port NES controller serialiser with standard and Four Score multitap report formats.
// Define JOYPAD_TURBO_EN to compile in per-pad turbo A/B autofire; without it turbo inputs are ignored.
module nes_joypad_mux #(
    parameter int unsigned NUM_PADS  = 2,
    parameter bit          FILL_BIT  = 1'b1,
    parameter int unsigned TURBO_DIV = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  joypad_out,
    input  logic [1:0]            joypad_clock,
    input  logic [NUM_PADS*8-1:0] pad_buttons,
    input  logic                  fourscore_en,
    input  logic [NUM_PADS-1:0]   turbo_a,
    input  logic [NUM_PADS-1:0]   turbo_b,
    output logic [1:0]            port_data,
    output logic                  fourscore_active
);

    logic [7:0]       pad [4];
    logic [1:0][23:0] sr_q, sr_d, load;
    logic [1:0]       clk_q;
    logic             fs_q, fs_d;

`ifdef JOYPAD_TURBO_EN
    logic       strobe_q;
    logic [7:0] turbo_cnt_q;
    logic       phase_q;

    // Turbo phase advances once per TURBO_DIV strobes, counted on strobe rising edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            strobe_q    <= 1'b0;
            turbo_cnt_q <= 8'd0;
            phase_q     <= 1'b0;
        end else begin
            strobe_q <= joypad_out;
            if (joypad_out && !strobe_q) begin
                if (turbo_cnt_q == 8'(TURBO_DIV - 1)) begin
                    turbo_cnt_q <= 8'd0;
                    phase_q     <= ~phase_q;
                end else begin
                    turbo_cnt_q <= turbo_cnt_q + 8'd1;
                end
            end
        end
    end
`else
    logic unused_turbo;
    assign unused_turbo = ^{turbo_a, turbo_b} ^ (TURBO_DIV == 0);
`endif

    for (genvar n = 0; n < 4; n++) begin : g_pad
        if (n < NUM_PADS) begin : g_present
            logic [7:0] raw;
            assign raw = pad_buttons[8*n +: 8];
`ifdef JOYPAD_TURBO_EN
            assign pad[n] = {raw[7:2], raw[1] | (turbo_b[n] & phase_q),
                             raw[0] | (turbo_a[n] & phase_q)};
`else
            assign pad[n] = raw;
`endif
        end else begin : g_absent
            assign pad[n] = 8'h00;
        end
    end

    always_comb begin
        if (fourscore_en) begin
            load[0] = {8'h10, pad[2], pad[0]};
            load[1] = {8'h20, pad[3], pad[1]};
        end else begin
            load[0] = {{16{FILL_BIT}}, pad[0]};
            // A port with no pad behind it reads as all zeros, not fill.
            load[1] = (NUM_PADS > 1) ? {{16{FILL_BIT}}, pad[1]} : 24'h000000;
        end
    end

    always_comb begin
        sr_d = sr_q;
        fs_d = fs_q;
        if (joypad_out) begin
            sr_d = load;
            fs_d = fourscore_en;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (clk_q[i] && !joypad_clock[i]) begin
                    sr_d[i] = {FILL_BIT, sr_q[i][23:1]};
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q  <= '0;
            clk_q <= 2'b00;
            fs_q  <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            clk_q <= joypad_clock;
            fs_q  <= fs_d;
        end
    end

    assign port_data        = {sr_q[1][0], sr_q[0][0]};
    assign fourscore_active = fs_q;

endmodule

// File: tb/tb_nes_joypad_mux.sv
// Self-checking bench for nes_joypad_mux: directed scenarios plus randomized traffic
// compared against a report-level model (bit list + read index per port).
module tb_nes_joypad_mux;

    localparam int unsigned N_PADS = 4;
    localparam int unsigned DIV    = 2;
    localparam bit          FILL   = 1'b1;
`ifdef JOYPAD_TURBO_EN
    localparam bit TURBO = 1'b1;
`else
    localparam bit TURBO = 1'b0;
`endif

    logic                clk, reset, joypad_out, fourscore_en, fourscore_active;
    logic [1:0]          joypad_clock, port_data;
    logic [N_PADS*8-1:0] pad_buttons;
    logic [N_PADS-1:0]   turbo_a, turbo_b;

    int n_cmp, n_err;

    // Model: the 24-bit report of each port as a bit list plus how many bits were consumed.
    bit       m_bits [2][24];
    int       m_idx  [2];
    bit       m_fs;
    bit [1:0] m_clk;
    bit       m_strobe;
    int       m_strobes;

    nes_joypad_mux #(
        .NUM_PADS  (N_PADS),
        .FILL_BIT  (FILL),
        .TURBO_DIV (DIV)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .joypad_out       (joypad_out),
        .joypad_clock     (joypad_clock),
        .pad_buttons      (pad_buttons),
        .fourscore_en     (fourscore_en),
        .turbo_a          (turbo_a),
        .turbo_b          (turbo_b),
        .port_data        (port_data),
        .fourscore_active (fourscore_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pad_val(int n, bit ph);
        logic [7:0] v;
        if (n >= int'(N_PADS)) return 8'h00;
        v = pad_buttons[8*n +: 8];
        v[0] = v[0] | (turbo_a[n] & ph & TURBO);
        v[1] = v[1] | (turbo_b[n] & ph & TURBO);
        return v;
    endfunction

    function automatic bit m_exp(int p);
        return (m_idx[p] < 24) ? m_bits[p][m_idx[p]] : FILL;
    endfunction

    task automatic m_reset();
        for (int p = 0; p < 2; p++) begin
            for (int j = 0; j < 24; j++) m_bits[p][j] = 1'b0;
            m_idx[p] = 0;
        end
        m_fs = 1'b0; m_clk = 2'b00; m_strobe = 1'b0; m_strobes = 0;
    endtask

    task automatic m_reload();
        bit         ph;
        logic [7:0] byte_v;
        ph = ((m_strobes / int'(DIV)) % 2) == 1;
        for (int p = 0; p < 2; p++) begin
            for (int j = 0; j < 24; j++) begin
                if (!fourscore_en) begin
                    byte_v = pad_val(p, ph);
                    if (p >= int'(N_PADS)) m_bits[p][j] = 1'b0;
                    else if (j < 8)        m_bits[p][j] = byte_v[j];
                    else                   m_bits[p][j] = FILL;
                end else begin
                    case (j / 8)
                        0:       byte_v = pad_val(p, ph);
                        1:       byte_v = pad_val(p + 2, ph);
                        default: byte_v = (p == 0) ? 8'h10 : 8'h20;
                    endcase
                    m_bits[p][j] = byte_v[j % 8];
                end
            end
            m_idx[p] = 0;
        end
        m_fs = fourscore_en;
    endtask

    // Advance one clock: model consumes the inputs seen at the edge, outputs settle 1ns after.
    task automatic tick();
        if (joypad_out) m_reload();
        else begin
            for (int p = 0; p < 2; p++)
                if (m_clk[p] && !joypad_clock[p] && m_idx[p] < 24) m_idx[p]++;
        end
        if (joypad_out && !m_strobe) m_strobes++;
        m_clk = joypad_clock;
        m_strobe = joypad_out;
        @(posedge clk);
        #1;
    endtask

    task automatic fall(int p);
        joypad_clock[p] = 1'b1; tick();
        joypad_clock[p] = 1'b0; tick();
    endtask

    task automatic strobe(int cycles);
        joypad_out = 1'b1;
        repeat (cycles) tick();
        joypad_out = 1'b0;
        tick();
    endtask

    task automatic apply_reset();
        reset = 1'b1; m_reset();
        joypad_out = 1'b0; joypad_clock = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        pad_buttons = $urandom; fourscore_en = 1'b1; joypad_out = 1'b1;
        joypad_clock = 2'b11; turbo_a = '0; turbo_b = '0;
        reset = 1'b1; m_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (port_data !== 2'b00) begin
            n_err++; $display("FAIL reset_port_data: got %b expected 00", port_data);
        end
        n_cmp++;
        if (fourscore_active !== 1'b0) begin
            n_err++; $display("FAIL reset_fourscore_active: got %b expected 0", fourscore_active);
        end
        joypad_out = 1'b0; joypad_clock = 2'b00; reset = 1'b0;
        tick();
        n_cmp++;
        if (port_data !== {m_exp(1), m_exp(0)}) begin
            n_err++; $display("FAIL reset_release: got %b expected %b", port_data, {m_exp(1), m_exp(0)});
        end
    endtask

    task automatic test_standard_a5();
        logic [9:0] exp_seq;
        exp_seq = 10'h3A5;
        pad_buttons = $urandom; pad_buttons[7:0] = 8'hA5;
        fourscore_en = 1'b0; turbo_a = '0; turbo_b = '0;
        strobe(1);
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (port_data[0] !== exp_seq[i]) begin
                n_err++; $display("FAIL std_a5 bit %0d: got %b expected %b", i, port_data[0], exp_seq[i]);
            end
            fall(0);
        end
    endtask

    task automatic test_fourscore();
        logic [23:0] e1, e2;
        bit          x1, x2;
        e1 = 24'h100401; e2 = 24'h200802;
        pad_buttons = 32'h08040201; fourscore_en = 1'b1;
        strobe(2);
        n_cmp++;
        if (fourscore_active !== 1'b1) begin
            n_err++; $display("FAIL fs_active_set: got %b expected 1", fourscore_active);
        end
        // Mode and buttons change mid-read; the loaded report must be unaffected.
        fourscore_en = 1'b0; pad_buttons = $urandom;
        for (int i = 0; i < 25; i++) begin
            x1 = (i < 24) ? e1[i] : FILL;
            x2 = (i < 24) ? e2[i] : FILL;
            n_cmp++;
            if (port_data !== {x2, x1}) begin
                n_err++; $display("FAIL fourscore bit %0d: got %b expected %b", i, port_data, {x2, x1});
            end
            fall(0); fall(1);
        end
        n_cmp++;
        if (fourscore_active !== 1'b1) begin
            n_err++; $display("FAIL fs_active_hold: got %b expected 1", fourscore_active);
        end
    endtask

    task automatic test_strobe_hold();
        pad_buttons = $urandom; fourscore_en = 1'b0;
        joypad_out = 1'b1; tick();
        for (int k = 0; k < 3; k++) begin
            joypad_clock[0] = 1'b1; tick();
            joypad_clock[0] = 1'b0; tick();
            n_cmp++;
            if (port_data[0] !== pad_buttons[0]) begin
                n_err++; $display("FAIL strobe_hold %0d: got %b expected %b", k, port_data[0], pad_buttons[0]);
            end
        end
        joypad_out = 1'b0; tick();
        fall(0);
        n_cmp++;
        if (port_data[0] !== pad_buttons[1]) begin
            n_err++; $display("FAIL strobe_hold_next: got %b expected %b", port_data[0], pad_buttons[1]);
        end
    endtask

    task automatic test_reload_wins();
        pad_buttons = $urandom; pad_buttons[7:0] = 8'h03; fourscore_en = 1'b0;
        strobe(1);
        joypad_clock[0] = 1'b1; tick();
        pad_buttons[7:0] = 8'h02; joypad_out = 1'b1; joypad_clock[0] = 1'b0;
        tick();
        n_cmp++;
        if (port_data[0] !== 1'b0) begin
            n_err++; $display("FAIL reload_wins: got %b expected 0", port_data[0]);
        end
        joypad_out = 1'b0; tick();
        fall(0);
        n_cmp++;
        if (port_data[0] !== 1'b1) begin
            n_err++; $display("FAIL reload_wins_next: got %b expected 1", port_data[0]);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] p0, p1;
        p0 = 8'hA5; p1 = 8'h5A;
        pad_buttons = $urandom; pad_buttons[15:0] = {p1, p0}; fourscore_en = 1'b0;
        strobe(1);
        repeat (5) fall(0);
        repeat (3) fall(1);
        n_cmp++;
        if (port_data !== {p1[3], p0[5]}) begin
            n_err++; $display("FAIL pre_reset: got %b expected %b", port_data, {p1[3], p0[5]});
        end
        joypad_clock = 2'b11;
        #2;
        reset = 1'b1; m_reset();
        #1;
        n_cmp++;
        if (port_data !== 2'b00) begin
            n_err++; $display("FAIL async_reset: got %b expected 00", port_data);
        end
        @(posedge clk);
        #1;
        joypad_clock = 2'b00; reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fall(0);
            n_cmp++;
            if (port_data[0] !== 1'b0) begin
                n_err++; $display("FAIL aborted_read %0d: got %b expected 0", i, port_data[0]);
            end
        end
        strobe(1);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (port_data !== {p1[i], p0[i]}) begin
                n_err++; $display("FAIL restart bit %0d: got %b expected %b", i, port_data, {p1[i], p0[i]});
            end
            fall(0); fall(1);
        end
    endtask

    task automatic test_saturation();
        bit x;
        pad_buttons = $urandom; fourscore_en = 1'b0;
        strobe(1);
        for (int i = 0; i < 30; i++) begin
            x = (i < 8) ? pad_buttons[8 + i] : FILL;
            n_cmp++;
            if (port_data !== {x, pad_buttons[0]}) begin
                n_err++; $display("FAIL saturate bit %0d: got %b expected %b", i, port_data, {x, pad_buttons[0]});
            end
            fall(1);
        end
    endtask

    task automatic test_turbo();
        logic [7:0] pattern;
        pattern = TURBO ? 8'h66 : 8'h00;
        apply_reset();
        pad_buttons = '0; turbo_a = 4'b0001; turbo_b = '0; fourscore_en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            strobe(2);
            n_cmp++;
            if (port_data[0] !== pattern[k]) begin
                n_err++; $display("FAIL turbo strobe %0d: got %b expected %b", k, port_data[0], pattern[k]);
            end
        end
        turbo_a = '0;
    endtask

    task automatic test_random();
        int prob;
        for (int i = 0; i < 800; i++) begin
            prob = (i < 300) ? 8 : 60;
            pad_buttons  = $urandom;
            fourscore_en = $urandom_range(1);
            turbo_a      = $urandom;
            turbo_b      = $urandom;
            joypad_out   = ($urandom_range(prob - 1) == 0);
            joypad_clock = $urandom;
            tick();
            n_cmp++;
            if (port_data !== {m_exp(1), m_exp(0)} || fourscore_active !== m_fs) begin
                n_err++;
                $display("FAIL random cycle %0d: got data=%b fs=%b expected data=%b fs=%b",
                         i, port_data, fourscore_active, {m_exp(1), m_exp(0)}, m_fs);
            end
        end
        joypad_out = 1'b0; joypad_clock = 2'b00;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        reset = 1'b1; joypad_out = 1'b0; joypad_clock = 2'b00;
        pad_buttons = '0; fourscore_en = 1'b0; turbo_a = '0; turbo_b = '0;
        m_reset();
        test_reset();
        test_standard_a5();
        test_fourscore();
        test_strobe_hold();
        test_reload_wins();
        test_reset_mid_read();
        test_saturation();
        test_turbo();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
